// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) and restoring divide sequencer.
// Drives an external shared add/sub ALU one iteration per clock.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sel,
  input  logic [WIDTH-1:0] alu_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    ctr;
  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] hi_nx, lo_nx, s, mb;
  logic             cy, bw, top, last;

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);
  assign last = (ctr == CW'(WIDTH - 1));

  // hi/lo double as HI/LO for multiply and R/Q for divide; m holds M or D.
  always_comb begin
    state_nx = state;
    alu_a    = '0;
    alu_b    = '0;
    alu_sel  = 1'b0;
    hi_nx    = hi;
    lo_nx    = lo;
    s        = {hi[WIDTH-2:0], lo[WIDTH-1]};
    top      = hi[WIDTH-1];
    mb       = lo[0] ? m : '0;
    cy       = 1'b0;
    bw       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (!op)              state_nx = S_MUL;
          else if (src_b == '0) state_nx = S_DONE;
          else                  state_nx = S_DIV;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_MUL: begin
        alu_a = hi;
        alu_b = mb;
        cy    = (hi[WIDTH-1] & mb[WIDTH-1]) |
                ((hi[WIDTH-1] | mb[WIDTH-1]) & ~alu_c[WIDTH-1]);
        hi_nx = {cy, alu_c[WIDTH-1:1]};
        lo_nx = {alu_c[0], lo[WIDTH-1:1]};
        if (last) state_nx = S_DONE;
      end
      S_DIV: begin
        alu_a   = s;
        alu_b   = m;
        alu_sel = 1'b1;
        bw      = (~s[WIDTH-1] & m[WIDTH-1]) |
                  ((~s[WIDTH-1] | m[WIDTH-1]) & alu_c[WIDTH-1]);
        // A set shifted-out bit means s exceeds D even if the ALU reports a borrow.
        if (top | ~bw) begin
          hi_nx = alu_c;
          lo_nx = {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi_nx = s;
          lo_nx = {lo[WIDTH-2:0], 1'b0};
        end
        if (last) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr         <= '0;
      hi          <= '0;
      lo          <= '0;
      m           <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            ctr         <= '0;
            hi          <= '0;
            lo          <= src_a;
            m           <= src_b;
            div_by_zero <= op & (src_b == '0);
            if (op && (src_b == '0)) begin
              result_lo <= '1;
              result_hi <= src_a;
            end
          end
        end
        S_MUL, S_DIV: begin
          ctr <= ctr + CW'(1);
          hi  <= hi_nx;
          lo  <= lo_nx;
          if (last) begin
            result_hi <= hi_nx;
            result_lo <= lo_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed and random ops against a
// plain-arithmetic reference model, with the shared ALU modelled combinationally.
module tb_alu_muldiv_seq;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, div_by_zero, alu_sel;
  logic [W-1:0] result_lo, result_hi, alu_a, alu_b, alu_c;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  assign alu_c = alu_sel ? (alu_a - alu_b) : (alu_a + alu_b);

  function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] lo, output logic [W-1:0] hi, output logic z);
    logic [2*W-1:0] p;
    z = 1'b0;
    if (!o) begin
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      lo = p[W-1:0];
      hi = p[2*W-1:W];
    end else if (b == '0) begin
      lo = '1;
      hi = a;
      z  = 1'b1;
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic launch(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat = cycle index of the done pulse after the start edge, -1 on timeout
  task automatic wait_done(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
    vectors++; if (result_lo !== '0 || result_hi !== '0) begin miscompares++; $display("FAIL reset_results got %h/%h exp 0/0", result_hi, result_lo); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (alu_a !== '0 || alu_b !== '0 || alu_sel !== 1'b0) begin miscompares++; $display("FAIL idle_alu got a=%h b=%h sel=%b exp 0", alu_a, alu_b, alu_sel); end
  endtask

  task automatic test_mul;
    int lat, bc;
    launch(1'b0, 32'd7, 32'd6);
    wait_done(lat, bc);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL mul7x6_latency got %0d exp 33", lat); end
    vectors++; if (bc !== 32) begin miscompares++; $display("FAIL mul7x6_busy got %0d exp 32", bc); end
    vectors++; if (result_lo !== 32'h2A || result_hi !== '0) begin miscompares++; $display("FAIL mul7x6 got %h/%h exp 0/2a", result_hi, result_lo); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL mul7x6_dbz got %b exp 0", div_by_zero); end
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL done_pulse got done=%b busy=%b exp 0/0", done, busy); end
    vectors++; if (result_lo !== 32'h2A) begin miscompares++; $display("FAIL result_hold got %h exp 2a", result_lo); end
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    vectors++; if (result_hi !== 32'hFFFF_FFFE || result_lo !== 32'h1) begin miscompares++; $display("FAIL mul_max got %h/%h exp fffffffe/00000001", result_hi, result_lo); end
  endtask

  task automatic test_div;
    int lat, bc;
    launch(1'b1, 32'd100, 32'd7);
    wait_done(lat, bc);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL div_latency got %0d exp 33", lat); end
    vectors++; if (result_lo !== 32'd14 || result_hi !== 32'd2) begin miscompares++; $display("FAIL div100_7 got r=%0d q=%0d exp r=2 q=14", result_hi, result_lo); end
    launch(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    wait_done(lat, bc);
    vectors++; if (result_lo !== 32'h1 || result_hi !== 32'h7FFF_FFFE) begin miscompares++; $display("FAIL div_topbit got r=%h q=%h exp r=7ffffffe q=1", result_hi, result_lo); end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    launch(1'b1, 32'h1234, 32'h0);
    wait_done(lat, bc);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL dbz_latency got %0d exp 1", lat); end
    vectors++; if (bc !== 0) begin miscompares++; $display("FAIL dbz_busy got %0d exp 0", bc); end
    vectors++; if (result_lo !== 32'hFFFF_FFFF || result_hi !== 32'h1234) begin miscompares++; $display("FAIL dbz_results got %h/%h exp 00001234/ffffffff", result_hi, result_lo); end
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_flag got %b exp 1", div_by_zero); end
    @(negedge clk);
    vectors++; if (div_by_zero !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL dbz_hold got dbz=%b done=%b exp 1/0", div_by_zero, done); end
  endtask

  task automatic test_start_ignored;
    int lat, bc;
    logic [W-1:0] elo, ehi;
    logic ez;
    model(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, elo, ehi, ez);
    launch(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ign_busy got %b exp 1", busy); end
    start = 1'b1; op = 1'b1; src_a = 32'd5; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    vectors++; if (lat !== 28) begin miscompares++; $display("FAIL ign_latency got %0d exp 28", lat); end
    vectors++; if (result_lo !== elo || result_hi !== ehi) begin miscompares++; $display("FAIL ign_result got %h/%h exp %h/%h", result_hi, result_lo, ehi, elo); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL ign_dbz got %b exp 0", div_by_zero); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [W-1:0] a1, b1, a2, b2, elo, ehi;
    logic ez;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom_range(1, 32'h7FFF_FFFF);
    launch(1'b0, a1, b1);
    wait_done(lat, bc);
    model(1'b0, a1, b1, elo, ehi, ez);
    vectors++; if (lat !== 33 || result_lo !== elo || result_hi !== ehi) begin miscompares++; $display("FAIL b2b_first got lat=%0d %h/%h exp 33 %h/%h", lat, result_hi, result_lo, ehi, elo); end
    start = 1'b1; op = 1'b1; src_a = a2; src_b = b2;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_handoff got done=%b busy=%b exp 0/1", done, busy); end
    wait_done(lat, bc);
    model(1'b1, a2, b2, elo, ehi, ez);
    vectors++; if (lat !== 32) begin miscompares++; $display("FAIL b2b_latency got %0d exp 32", lat); end
    vectors++; if (result_lo !== elo || result_hi !== ehi) begin miscompares++; $display("FAIL b2b_second got %h/%h exp %h/%h", result_hi, result_lo, ehi, elo); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic o, ez;
    logic [W-1:0] a, b, elo, ehi;
    for (int n = 0; n < 24; n++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      model(o, a, b, elo, ehi, ez);
      launch(o, a, b);
      wait_done(lat, bc);
      vectors++; if (lat !== (ez ? 1 : 33)) begin miscompares++; $display("FAIL rand%0d_latency got %0d exp %0d", n, lat, ez ? 1 : 33); end
      vectors++; if (result_lo !== elo || result_hi !== ehi) begin miscompares++; $display("FAIL rand%0d op=%b a=%h b=%h got %h/%h exp %h/%h", n, o, a, b, result_hi, result_lo, ehi, elo); end
      vectors++; if (div_by_zero !== ez) begin miscompares++; $display("FAIL rand%0d_dbz got %b exp %b", n, div_by_zero, ez); end
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    launch(1'b0, 32'd7, 32'd6);
    wait_done(lat, bc);
    launch(1'b1, 32'hDEAD_BEEF, 32'h1234);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl got busy=%b done=%b exp 0/0", busy, done); end
    vectors++; if (result_lo !== '0 || result_hi !== '0 || div_by_zero !== 1'b0) begin miscompares++; $display("FAIL rstmid_results got %h/%h dbz=%b exp 0", result_hi, result_lo, div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    launch(1'b0, 32'd3, 32'd5);
    wait_done(lat, bc);
    vectors++; if (lat !== 33 || result_lo !== 32'd15 || result_hi !== '0) begin miscompares++; $display("FAIL rstmid_mul3x5 got lat=%0d %h/%h exp 33 0/f", lat, result_hi, result_lo); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
